ks_msg_seq: RTL and testbench

Timed message sequencer that sits directly upstream of the string control wrapper. The host pushes control messages, each with a frame delay, into a small queue. The block releases them one per `lrck` frame as a single-cycle `msg_en` strobe with `msg_addr`/`msg`, letting the host pre-load note events (pluck, parameter sweeps) with sample-accurate timing.

---
 rtl/ks_pkg.sv | 24 ++
 rtl/ks_msg_fifo.sv | 56 +++++
 rtl/ks_msg_seq.sv | 139 +++++++++++++
 tb/tb_ks_msg_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared constants, payload layout and FSM states for the timed message sequencer.
package ks_pkg;

    localparam int unsigned KS_ADDR_W    = 9;
    localparam int unsigned KS_MSG_W     = 32;
    localparam int unsigned KS_PANIC_BIT = 1;
    localparam int unsigned KS_PLUCK_BIT = 0;

    typedef struct packed {
        logic [KS_ADDR_W-1:0] addr;
        logic [KS_MSG_W-1:0]  msg;
    } ks_payload_t;

    typedef enum logic {
        IDLE,
        WAIT
    } ks_state_t;

    // Queue entry is {wait, addr, msg}; wait width is a block parameter.
    function automatic int unsigned ks_entry_w(input int unsigned wait_w);
        return wait_w + KS_ADDR_W + KS_MSG_W;
    endfunction

endpackage

// File: rtl/ks_msg_fifo.sv
// Synchronous FIFO with occupancy count; clear has priority over push and pop.
module ks_msg_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/ks_msg_seq.sv
// Timed message sequencer: queued messages issued one per frame after per-entry delays.
// Optional KS_SEQ_PANIC_BYPASS_EN: panic pushes skip the queue and issue at once.
module ks_msg_seq
    import ks_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WAIT_W = 16
) (
    input  logic                   lrck,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [KS_ADDR_W-1:0]   in_addr,
    input  logic [KS_MSG_W-1:0]    in_msg,
    input  logic [WAIT_W-1:0]      in_wait,
    input  logic                   flush,
    output logic                   msg_en,
    output logic [KS_ADDR_W-1:0]   msg_addr,
    output logic [KS_MSG_W-1:0]    msg,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);

    localparam int unsigned EW = ks_entry_w(WAIT_W);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_clear;
    logic [EW-1:0]     fifo_rdata;
    logic [LW-1:0]     level_d;
    logic              panic_c;

    ks_state_t         state_q;
    ks_state_t         state_d;
    logic [WAIT_W-1:0] hold_wait_q;
    logic [WAIT_W-1:0] hold_wait_d;
    ks_payload_t       hold_q;
    ks_payload_t       hold_d;
    ks_payload_t       out_d;
    logic              msg_en_d;
    logic              busy_d;

`ifdef KS_SEQ_PANIC_BYPASS_EN
    assign in_ready = !flush && (!fifo_full || in_msg[KS_PANIC_BIT]);
    assign panic_c  = in_valid && in_ready && in_msg[KS_PANIC_BIT];
`else
    assign in_ready = !flush && !fifo_full;
    assign panic_c  = 1'b0;
`endif

    assign fifo_push  = in_valid && in_ready && !panic_c;
    assign fifo_clear = flush || panic_c;

    ks_msg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (lrck),
        .rst_n (rst_n),
        .clear (fifo_clear),
        .push  (fifo_push),
        .wdata ({in_wait, in_addr, in_msg}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Head FSM: load hold from the queue, count down, issue, chain next entry.
    always_comb begin
        state_d     = state_q;
        hold_wait_d = hold_wait_q;
        hold_d      = hold_q;
        fifo_pop    = 1'b0;
        msg_en_d    = 1'b0;
        out_d       = '{addr: msg_addr, msg: msg};

        if (fifo_clear) begin
            state_d = IDLE;
            if (panic_c) begin
                msg_en_d = 1'b1;
                out_d    = '{addr: in_addr, msg: in_msg};
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop              = 1'b1;
                        {hold_wait_d, hold_d} = fifo_rdata;
                        state_d               = WAIT;
                    end
                end
                WAIT: begin
                    if (hold_wait_q != '0) begin
                        hold_wait_d = hold_wait_q - WAIT_W'(1);
                    end else begin
                        msg_en_d = 1'b1;
                        out_d    = hold_q;
                        if (!fifo_empty) begin
                            fifo_pop              = 1'b1;
                            {hold_wait_d, hold_d} = fifo_rdata;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        level_d = fifo_clear ? '0 : (level + LW'(fifo_push) - LW'(fifo_pop));
        busy_d  = (level_d != '0) || (state_d == WAIT);
    end

    always_ff @(posedge lrck or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_wait_q <= '0;
            hold_q      <= '0;
            msg_en      <= 1'b0;
            msg_addr    <= '0;
            msg         <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_wait_q <= hold_wait_d;
            hold_q      <= hold_d;
            msg_en      <= msg_en_d;
            msg_addr    <= out_d.addr;
            msg         <= out_d.msg;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_ks_msg_seq.sv
// Scoreboard bench for ks_msg_seq: issue times derived from push times and delays.
module tb_ks_msg_seq;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned WAIT_W = 16;
`ifdef KS_SEQ_PANIC_BYPASS_EN
    localparam bit PANIC_EN = 1'b1;
`else
    localparam bit PANIC_EN = 1'b0;
`endif

    logic                   lrck = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [8:0]             in_addr;
    logic [31:0]            in_msg;
    logic [WAIT_W-1:0]      in_wait;
    logic                   flush;
    logic                   msg_en;
    logic [8:0]             msg_addr;
    logic [31:0]            msg;
    logic [$clog2(DEPTH):0] level;
    logic                   busy;

    ks_msg_seq #(.DEPTH(DEPTH), .WAIT_W(WAIT_W)) dut (
        .lrck     (lrck),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_msg   (in_msg),
        .in_wait  (in_wait),
        .flush    (flush),
        .msg_en   (msg_en),
        .msg_addr (msg_addr),
        .msg      (msg),
        .level    (level),
        .busy     (busy)
    );

    always #5 lrck = ~lrck;

    int cyc = 0;
    always @(posedge lrck) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [8:0]  a;
        logic [31:0] m;
    } exp_t;

    typedef struct {
        int push;
        int load;
        int issue;
    } ent_t;

    exp_t        sb[$];
    ent_t        ents[$];
    int          last_issue = 0;
    logic [8:0]  last_a = '0;
    logic [31:0] last_m = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Entry sits in the queue for push <= c < load, counts as busy until its issue edge.
    function automatic int m_level(input int c);
        int k = 0;
        foreach (ents[i]) if (ents[i].push <= c && c < ents[i].load) k++;
        return k;
    endfunction

    function automatic bit m_busy(input int c);
        foreach (ents[i]) if (ents[i].push <= c && c < ents[i].issue) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void kill(input int n);
        while (sb.size() > 0 && sb[$].c >= n) void'(sb.pop_back());
        while (ents.size() > 0 && ents[$].issue >= n) void'(ents.pop_back());
        last_issue = 0;
    endfunction

    // Monitor: outputs after edge cyc against the model.
    initial begin
        bit due;
        forever begin
            @(negedge lrck);
            chk("level", 64'(level), 64'(m_level(cyc)));
            chk("busy", 64'(busy), 64'(m_busy(cyc)));
            due = (sb.size() > 0) && (sb[0].c <= cyc);
            if (msg_en || due) begin
                chk("msg_en", 64'(msg_en), 64'(due));
                if (due) begin
                    last_a = sb[0].a;
                    last_m = sb[0].m;
                    void'(sb.pop_front());
                end
            end
            chk("msg_addr", 64'(msg_addr), 64'(last_a));
            chk("msg", 64'(msg), 64'(last_m));
        end
    end

    // One frame of stimulus applied for edge cyc+1, with the model advanced alongside.
    task automatic step(input logic v, input logic [8:0] a, input logic [31:0] m,
                        input logic [WAIT_W-1:0] w, input logic f);
        int   n;
        bit   pan;
        bit   rdy;
        ent_t e;
        exp_t x;
        @(negedge lrck);
        #1;
        in_valid = v; in_addr = a; in_msg = m; in_wait = w; flush = f;
        n = cyc + 1;
        while (ents.size() > 0 && ents[0].issue < cyc) void'(ents.pop_front());
        pan = PANIC_EN && m[1];
        rdy = !f && ((m_level(cyc) < int'(DEPTH)) || pan);
        #1;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        if (f) begin
            kill(n);
        end else if (v && rdy) begin
            x.a = a; x.m = m;
            if (pan) begin
                kill(n);
                x.c = n;
                last_issue = n;
            end else begin
                e.push  = n;
                e.load  = (last_issue > n + 1) ? last_issue : n + 1;
                e.issue = e.load + 1 + int'(w);
                ents.push_back(e);
                x.c = e.issue;
                last_issue = e.issue;
            end
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 9'h0, 32'h0, '0, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        @(negedge lrck);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        sb.delete(); ents.delete();
        last_issue = 0; last_a = '0; last_m = '0;
        #1;
        chk("rst_msg_en", 64'(msg_en), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_msg", 64'({msg_addr, msg}), 64'd0);
        repeat (hold) @(negedge lrck);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int budget;
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_msg = '0; in_wait = '0; flush = 1'b0;
        repeat (3) @(negedge lrck);
        #1;
        rst_n = 1'b1;

        // Single message, wait 0.
        step(1'b1, 9'h040, 32'h0000_0001, 16'd0, 1'b0);
        idle(6);

        // Back-to-back waits 0, 3, 0.
        step(1'b1, 9'h011, 32'h1111_0000, 16'd0, 1'b0);
        step(1'b1, 9'h022, 32'h2222_0000, 16'd3, 1'b0);
        step(1'b1, 9'h033, 32'h3333_0000, 16'd0, 1'b0);
        idle(10);

        // Fill with long waits, keep pushing until one more slot opens, then flush.
        for (int i = 0; i < 110; i++) step(1'b1, 9'(i), 32'(i) << 4, 16'd100, 1'b0);
        step(1'b1, 9'h1ff, 32'hdead_0000, 16'd0, 1'b1);
        idle(5);

        // Flush around a due issue with entries queued and a push in the same cycle.
        for (int i = 0; i < 5; i++) step(1'b1, 9'(i + 8'h80), 32'hc0de_0000 + 32'(i), 16'd3, 1'b0);
        step(1'b1, 9'h155, 32'h5555_5555, 16'd0, 1'b1);
        idle(8);

        // Panic push against a full queue.
        for (int i = 0; i < 10; i++) step(1'b1, 9'(i), 32'hf000_0000 + 32'(i) * 4, 16'd100, 1'b0);
        step(1'b1, 9'h0aa, 32'h0000_0002, 16'd50, 1'b0);
        idle(3);
        step(1'b0, 9'h0, 32'h0, '0, 1'b1);
        idle(3);

        // Reset mid-wait.
        step(1'b1, 9'h077, 32'h7777_7777, 16'd20, 1'b0);
        idle(5);
        do_reset(3);
        idle(40);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), 9'($urandom), $urandom,
                 ($urandom_range(0, 7) == 0) ? WAIT_W'($urandom_range(0, 20)) : WAIT_W'($urandom_range(0, 2)),
                 1'($urandom_range(0, 63) == 0));
        end

        budget = 0;
        while (sb.size() > 0 && budget < 800) begin
            idle(1);
            budget++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
